// File: rtl/wb_bus_arbiter_if.sv
// Wishbone shared-bus bundle between the masters, the arbiter and the slaves.
// The master modport is the surrounding fabric; the slave modport is the arbiter.
interface wb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int MSEL_W      = 3
);
  logic [NUM_MASTERS-1:0]    m_cyc_i;
  logic [NUM_MASTERS-1:0]    m_stb_i;
  logic [NUM_MASTERS-1:0]    m_we_i;
  logic [4*NUM_MASTERS-1:0]  m_sel_i;
  logic [32*NUM_MASTERS-1:0] m_adr_i;
  logic [32*NUM_MASTERS-1:0] m_dat_i;
  logic [31:0]               m_dat_o;
  logic [NUM_MASTERS-1:0]    m_ack_o;
  logic [NUM_MASTERS-1:0]    m_err_o;
  logic [31:0]               s_adr_o;
  logic [31:0]               s_dat_o;
  logic [3:0]                s_sel_o;
  logic                      s_we_o;
  logic [NUM_SLAVES-1:0]     s_cyc_o;
  logic [NUM_SLAVES-1:0]     s_stb_o;
  logic [32*NUM_SLAVES-1:0]  s_dat_i;
  logic [NUM_SLAVES-1:0]     s_ack_i;
  logic [NUM_SLAVES-1:0]     s_err_i;
  logic [MSEL_W-1:0]         msel_o;
  logic                      busy_o;

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output s_dat_i, s_ack_i, s_err_i,
    input  m_dat_o, m_ack_o, m_err_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  msel_o, busy_o
  );

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  s_dat_i, s_ack_i, s_err_i,
    output m_dat_o, m_ack_o, m_err_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output msel_o, busy_o
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Wishbone classic shared-bus interconnect: N masters arbitrated onto M slaves,
// with unmapped-address error, stall timeout and granted-master index.
module wb_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter logic [32*NUM_SLAVES-1:0] SLV_BASE =
    {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLV_MASK =
    {3{32'hF000_0000}},
  parameter int ARB_MODE    = 0,
  parameter int TIMEOUT     = 255,
  parameter int MSEL_W      = 3
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  wb_bus_arbiter_if.slave bus
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    ERR
  } state_t;

  state_t            state;
  logic [MW-1:0]     grant;
  logic [MW-1:0]     rr_ptr;
  logic [15:0]       tcnt;
  logic              busy_q;
  logic [MSEL_W-1:0] msel_q;

  logic [MW-1:0]     win;
  logic              found;
  int                cand;

  logic              g_cyc;
  logic              g_stb;
  logic              g_we;
  logic [3:0]        g_sel;
  logic [31:0]       g_adr;
  logic [31:0]       g_dat;

  logic              hit_any;
  logic [SW-1:0]     hit_idx;
  logic [NUM_SLAVES-1:0] hit_oh;

  logic              own;
  logic              live;
  logic              to_hit;
  logic              s_ack;
  logic              s_err;
  logic              ack_v;
  logic              err_v;

  // Round-robin scans upward from rr_ptr; fixed priority scans from 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ARB_MODE == 1) cand = i;
      else cand = (int'(rr_ptr) + i) % NUM_MASTERS;
      if (!found && bus.m_cyc_i[cand]) begin
        win   = MW'(cand);
        found = 1'b1;
      end
    end
  end

  assign g_cyc = bus.m_cyc_i[grant];
  assign g_stb = bus.m_stb_i[grant];
  assign g_we  = bus.m_we_i[grant];
  assign g_sel = bus.m_sel_i[4*grant +: 4];
  assign g_adr = bus.m_adr_i[32*grant +: 32];
  assign g_dat = bus.m_dat_i[32*grant +: 32];

  // Overlapping windows resolve to the lowest slave index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!hit_any &&
          ((g_adr & SLV_MASK[32*k +: 32]) == SLV_BASE[32*k +: 32])) begin
        hit_any   = 1'b1;
        hit_idx   = SW'(k);
        hit_oh[k] = 1'b1;
      end
    end
  end

  assign own    = (state == OWN) && !wb_rst_i;
  assign live   = own && g_cyc;
  assign to_hit = (TIMEOUT != 0) && (tcnt == 16'(TIMEOUT));
  assign s_ack  = hit_any && bus.s_ack_i[hit_idx];
  assign s_err  = hit_any && bus.s_err_i[hit_idx];
  assign ack_v  = live && g_stb && s_ack && !to_hit;
  assign err_v  = live && g_stb && s_err && !to_hit;

  always_comb begin
    bus.s_adr_o = own ? g_adr : '0;
    bus.s_dat_o = own ? g_dat : '0;
    bus.s_sel_o = own ? g_sel : '0;
    bus.s_we_o  = own && g_we;
    bus.s_cyc_o = live ? hit_oh : '0;
    bus.s_stb_o = (live && g_stb && !to_hit) ? hit_oh : '0;
    bus.m_ack_o = '0;
    bus.m_ack_o[grant] = ack_v;
    bus.m_err_o = '0;
    bus.m_err_o[grant] = err_v || ((state == ERR) && !wb_rst_i);
    bus.m_dat_o = (own && hit_any) ? bus.s_dat_i[32*hit_idx +: 32] : '0;
  end

  assign bus.msel_o = msel_q;
  assign bus.busy_o = busy_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      tcnt   <= '0;
      busy_q <= 1'b0;
      msel_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.m_cyc_i) begin
            grant  <= win;
            msel_q <= MSEL_W'(win);
            busy_q <= 1'b1;
            state  <= OWN;
          end
        end
        OWN: begin
          if (!g_cyc) begin
            state  <= IDLE;
            grant  <= '0;
            msel_q <= '0;
            busy_q <= 1'b0;
            tcnt   <= '0;
            rr_ptr <= (grant == MW'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
          end else if (g_stb && (!hit_any || to_hit)) begin
            state <= ERR;
            tcnt  <= '0;
          end else if (g_stb && !s_ack && !s_err && (TIMEOUT != 0)) begin
            tcnt <= tcnt + 16'd1;
          end else begin
            tcnt <= '0;
          end
        end
        ERR: state <= OWN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: one round-robin/default instance and
// one fixed-priority instance with a short stall timeout.
module tb_wb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.NUM_MASTERS(2), .NUM_SLAVES(3), .MSEL_W(3)) ia ();
  wb_bus_arbiter_if #(.NUM_MASTERS(2), .NUM_SLAVES(3), .MSEL_W(3)) ib ();

  wb_bus_arbiter #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .ARB_MODE(0), .TIMEOUT(255), .MSEL_W(3)
  ) dut_a (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(ia)
  );

  wb_bus_arbiter #(
    .NUM_MASTERS(2), .NUM_SLAVES(3), .ARB_MODE(1), .TIMEOUT(4), .MSEL_W(3)
  ) dut_b (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(ib)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    ia.m_cyc_i = '0; ia.m_stb_i = '0; ia.m_we_i = '0;
    ia.m_sel_i = '1; ia.m_adr_i = '0; ia.m_dat_i = '0;
    ia.s_dat_i = '0; ia.s_ack_i = '0; ia.s_err_i = '0;
    ib.m_cyc_i = '0; ib.m_stb_i = '0; ib.m_we_i = '0;
    ib.m_sel_i = '1; ib.m_adr_i = '0; ib.m_dat_i = '0;
    ib.s_dat_i = '0; ib.s_ack_i = '0; ib.s_err_i = '0;
  endtask

  task automatic test_reset();
    tick(); tick();
    #1;
    nvec++;
    if (ia.busy_o !== 1'b0) begin
      nmis++; $display("FAIL rst_busy got %b want 0", ia.busy_o);
    end
    nvec++;
    if (ia.msel_o !== 3'd0) begin
      nmis++; $display("FAIL rst_msel got %0d want 0", ia.msel_o);
    end
    nvec++;
    if (ia.s_stb_o !== 3'b000 || ia.m_ack_o !== 2'b00 || ia.m_err_o !== 2'b00) begin
      nmis++;
      $display("FAIL rst_outs got stb=%b ack=%b err=%b want 0",
               ia.s_stb_o, ia.m_ack_o, ia.m_err_o);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    tick();
    ia.m_cyc_i = 2'b01; ia.m_stb_i = 2'b01; ia.m_we_i = 2'b00;
    ia.m_adr_i[31:0] = 32'h1000_0010;
    #1;
    nvec++;
    if (ia.s_stb_o !== 3'b000) begin
      nmis++; $display("FAIL rd_latency got stb=%b want 000", ia.s_stb_o);
    end
    tick();
    nvec++;
    if (ia.s_stb_o !== 3'b010 || ia.msel_o !== 3'd0 || ia.busy_o !== 1'b1) begin
      nmis++;
      $display("FAIL rd_own got stb=%b msel=%0d busy=%b want 010/0/1",
               ia.s_stb_o, ia.msel_o, ia.busy_o);
    end
    nvec++;
    if (ia.s_adr_o !== 32'h1000_0010 || ia.m_ack_o !== 2'b00) begin
      nmis++;
      $display("FAIL rd_adr got adr=%h ack=%b want 10000010/00",
               ia.s_adr_o, ia.m_ack_o);
    end
    tick();
    tick();
    ia.s_ack_i = 3'b010;
    ia.s_dat_i[63:32] = 32'hDEAD_BEEF;
    #1;
    nvec++;
    if (ia.m_ack_o !== 2'b01 || ia.m_dat_o !== 32'hDEAD_BEEF) begin
      nmis++;
      $display("FAIL rd_ack got ack=%b dat=%h want 01/deadbeef",
               ia.m_ack_o, ia.m_dat_o);
    end
    tick();
    ia.s_ack_i = 3'b000;
    ia.m_cyc_i = 2'b00; ia.m_stb_i = 2'b00;
    #1;
    nvec++;
    if (ia.s_stb_o !== 3'b000) begin
      nmis++; $display("FAIL rd_release got stb=%b want 000", ia.s_stb_o);
    end
    tick();
    nvec++;
    if (ia.busy_o !== 1'b0 || ia.msel_o !== 3'd0) begin
      nmis++;
      $display("FAIL rd_idle got busy=%b msel=%0d want 0/0", ia.busy_o, ia.msel_o);
    end
  endtask

  task automatic test_unmapped();
    tick();
    ia.m_cyc_i = 2'b01; ia.m_stb_i = 2'b01;
    ia.m_adr_i[31:0] = 32'h5000_0000;
    #1;
    nvec++;
    if (ia.m_err_o !== 2'b00) begin
      nmis++; $display("FAIL um_err0 got %b want 00", ia.m_err_o);
    end
    tick();
    nvec++;
    if (ia.s_stb_o !== 3'b000 || ia.s_cyc_o !== 3'b000 || ia.m_err_o !== 2'b00) begin
      nmis++;
      $display("FAIL um_own got stb=%b cyc=%b err=%b want 000/000/00",
               ia.s_stb_o, ia.s_cyc_o, ia.m_err_o);
    end
    tick();
    nvec++;
    if (ia.m_err_o !== 2'b01 || ia.busy_o !== 1'b1) begin
      nmis++;
      $display("FAIL um_pulse got err=%b busy=%b want 01/1", ia.m_err_o, ia.busy_o);
    end
    tick();
    ia.m_cyc_i = 2'b00; ia.m_stb_i = 2'b00;
    #1;
    nvec++;
    if (ia.m_err_o !== 2'b00) begin
      nmis++; $display("FAIL um_once got err=%b want 00", ia.m_err_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    ia.m_cyc_i = 2'b01; ia.m_stb_i = 2'b01;
    ia.m_adr_i[31:0] = 32'h0000_0100;
    tick();
    nvec++;
    if (ia.s_stb_o !== 3'b001) begin
      nmis++; $display("FAIL rm_pre got stb=%b want 001", ia.s_stb_o);
    end
    ia.s_ack_i = 3'b001;
    #1;
    rst = 1'b1;
    #1;
    nvec++;
    if (ia.s_stb_o !== 3'b000 || ia.s_cyc_o !== 3'b000 || ia.m_ack_o !== 2'b00) begin
      nmis++;
      $display("FAIL rm_strobes got stb=%b cyc=%b ack=%b want 0",
               ia.s_stb_o, ia.s_cyc_o, ia.m_ack_o);
    end
    nvec++;
    if (ia.busy_o !== 1'b0 || ia.msel_o !== 3'd0 || ia.s_adr_o !== 32'h0) begin
      nmis++;
      $display("FAIL rm_regs got busy=%b msel=%0d adr=%h want 0",
               ia.busy_o, ia.msel_o, ia.s_adr_o);
    end
    ia.s_ack_i = 3'b000;
    ia.m_cyc_i = 2'b11; ia.m_stb_i = 2'b11;
    ia.m_adr_i = {32'h0000_0008, 32'h0000_0004};
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      logic [2:0] exp_m;
      logic [1:0] exp_a;
      exp_m = 3'(i % 2);
      exp_a = 2'b01 << (i % 2);
      tick();
      nvec++;
      if (ia.msel_o !== exp_m || ia.busy_o !== 1'b1) begin
        nmis++;
        $display("FAIL rr_grant%0d got msel=%0d busy=%b want %0d/1",
                 i, ia.msel_o, ia.busy_o, exp_m);
      end
      ia.s_ack_i = 3'b001;
      #1;
      nvec++;
      if (ia.m_ack_o !== exp_a) begin
        nmis++;
        $display("FAIL rr_ack%0d got %b want %b", i, ia.m_ack_o, exp_a);
      end
      tick();
      ia.s_ack_i = 3'b000;
      ia.m_cyc_i[i % 2] = 1'b0; ia.m_stb_i[i % 2] = 1'b0;
      tick();
      ia.m_cyc_i[i % 2] = 1'b1; ia.m_stb_i[i % 2] = 1'b1;
    end
    ia.m_cyc_i = 2'b00; ia.m_stb_i = 2'b00;
    tick();
  endtask

  task automatic test_locked_block();
    ia.m_cyc_i = 2'b10; ia.m_stb_i = 2'b10; ia.m_we_i = 2'b10;
    ia.m_adr_i = {32'h2000_0000, 32'h0000_0000};
    tick();
    nvec++;
    if (ia.msel_o !== 3'd1 || ia.s_stb_o !== 3'b100 || ia.s_we_o !== 1'b1) begin
      nmis++;
      $display("FAIL lk_grant got msel=%0d stb=%b we=%b want 1/100/1",
               ia.msel_o, ia.s_stb_o, ia.s_we_o);
    end
    ia.m_cyc_i = 2'b11; ia.m_stb_i = 2'b11;
    for (int j = 0; j < 4; j++) begin
      logic [31:0] ea;
      logic [31:0] ed;
      ea = 32'h2000_0000 + 32'(4 * j);
      ed = 32'hA5A5_0000 + 32'(j);
      ia.m_adr_i[63:32] = ea;
      ia.m_dat_i[63:32] = ed;
      ia.s_ack_i = 3'b100;
      #1;
      nvec++;
      if (ia.m_ack_o !== 2'b10 || ia.s_adr_o !== ea || ia.s_dat_o !== ed) begin
        nmis++;
        $display("FAIL lk_beat%0d got ack=%b adr=%h dat=%h want 10/%h/%h",
                 j, ia.m_ack_o, ia.s_adr_o, ia.s_dat_o, ea, ed);
      end
      tick();
    end
    ia.s_ack_i = 3'b000;
    ia.m_cyc_i = 2'b01; ia.m_stb_i = 2'b01; ia.m_we_i = 2'b00;
    #1;
    nvec++;
    if (ia.m_ack_o !== 2'b00 || ia.s_stb_o !== 3'b000) begin
      nmis++;
      $display("FAIL lk_drop got ack=%b stb=%b want 00/000", ia.m_ack_o, ia.s_stb_o);
    end
    tick();
    nvec++;
    if (ia.busy_o !== 1'b0) begin
      nmis++; $display("FAIL lk_idle got busy=%b want 0", ia.busy_o);
    end
    tick();
    nvec++;
    if (ia.msel_o !== 3'd0 || ia.s_stb_o !== 3'b001) begin
      nmis++;
      $display("FAIL lk_next got msel=%0d stb=%b want 0/001", ia.msel_o, ia.s_stb_o);
    end
    ia.m_cyc_i = 2'b00; ia.m_stb_i = 2'b00;
    tick(); tick();
  endtask

  task automatic test_timeout();
    tick();
    ib.m_cyc_i = 2'b01; ib.m_stb_i = 2'b01;
    ib.m_adr_i = '0;
    tick();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        #1;
        nvec++;
        if (ib.s_stb_o !== 3'b001 || ib.m_err_o !== 2'b00) begin
          nmis++;
          $display("FAIL to_stall%0d_%0d got stb=%b err=%b want 001/00",
                   r, c, ib.s_stb_o, ib.m_err_o);
        end
        tick();
      end
      #1;
      nvec++;
      if (ib.s_stb_o !== 3'b000 || ib.m_err_o !== 2'b00) begin
        nmis++;
        $display("FAIL to_hit%0d got stb=%b err=%b want 000/00",
                 r, ib.s_stb_o, ib.m_err_o);
      end
      tick();
      nvec++;
      if (ib.m_err_o !== 2'b01) begin
        nmis++; $display("FAIL to_err%0d got %b want 01", r, ib.m_err_o);
      end
      tick();
    end
    ib.m_cyc_i = 2'b00; ib.m_stb_i = 2'b00;
    tick();
    nvec++;
    if (ib.busy_o !== 1'b0) begin
      nmis++; $display("FAIL to_idle got busy=%b want 0", ib.busy_o);
    end
  endtask

  task automatic test_fixed_priority();
    ib.m_cyc_i = 2'b11; ib.m_stb_i = 2'b11;
    ib.m_adr_i = {32'h0000_0040, 32'h0000_0020};
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++;
      if (ib.msel_o !== 3'd0) begin
        nmis++; $display("FAIL fp_grant%0d got %0d want 0", i, ib.msel_o);
      end
      ib.s_ack_i = 3'b001;
      #1;
      nvec++;
      if (ib.m_ack_o !== 2'b01) begin
        nmis++; $display("FAIL fp_ack%0d got %b want 01", i, ib.m_ack_o);
      end
      tick();
      ib.s_ack_i = 3'b000;
      ib.m_cyc_i[0] = 1'b0; ib.m_stb_i[0] = 1'b0;
      tick();
      ib.m_cyc_i[0] = 1'b1; ib.m_stb_i[0] = 1'b1;
    end
    ib.m_cyc_i = 2'b00; ib.m_stb_i = 2'b00;
    tick();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_unmapped();
    test_reset_mid();
    test_round_robin();
    test_locked_block();
    test_timeout();
    test_fixed_priority();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
